// File: rtl/simon_control.sv
// Sequencing FSM for the Simon datapath: drives all datapath strobes and the mode LEDs.
// Optional round cap enabled by defining SIMON_ROUND_CAP_EN (uses parameter MAX_ROUNDS).
module simon_control
`ifdef SIMON_ROUND_CAP_EN
#(
    parameter int unsigned MAX_ROUNDS = 64
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       is_legal,
    input  logic       input_eq_pattern,
    input  logic       index_lt_count,
    output logic       w_en,
    output logic       set_level,
    output logic       read_Memory,
    output logic       cnt_count,
    output logic       clr_count,
    output logic       cnt_index,
    output logic       clr_index,
    output logic [2:0] mode_leds
);

    typedef enum logic [1:0] {
        StInput    = 2'b00,
        StPlayback = 2'b01,
        StRepeat   = 2'b10,
        StDone     = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   cap_hit;

`ifdef SIMON_ROUND_CAP_EN
    // Mirrors the datapath count so a full memory ends the game as a win.
    logic [6:0] rounds_q, rounds_d;

    always_comb begin
        rounds_d = rounds_q;
        if (reset) begin
            rounds_d = 7'd0;
        end else if (cnt_count) begin
            rounds_d = rounds_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        rounds_q <= rounds_d;
    end

    assign cap_hit = (rounds_q == 7'(MAX_ROUNDS));
`else
    assign cap_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = StInput;
        end else begin
            unique case (state_q)
                StInput: begin
                    if (is_legal) state_d = StPlayback;
                end
                StPlayback: begin
                    if (!index_lt_count) state_d = StRepeat;
                end
                StRepeat: begin
                    if (!index_lt_count) begin
                        state_d = cap_hit ? StDone : StInput;
                    end else if (!input_eq_pattern) begin
                        state_d = StDone;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StInput;
            endcase
        end
    end

    always_comb begin
        w_en        = 1'b0;
        set_level   = 1'b0;
        read_Memory = 1'b0;
        cnt_count   = 1'b0;
        clr_count   = 1'b0;
        cnt_index   = 1'b0;
        clr_index   = 1'b0;
        mode_leds   = 3'b001;
        if (reset) begin
            set_level = 1'b1;
            clr_count = 1'b1;
            clr_index = 1'b1;
        end else begin
            unique case (state_q)
                StInput: begin
                    mode_leds = 3'b001;
                    if (is_legal) begin
                        w_en      = 1'b1;
                        cnt_count = 1'b1;
                        clr_index = 1'b1;
                    end
                end
                StPlayback: begin
                    mode_leds   = 3'b010;
                    read_Memory = 1'b1;
                    cnt_index   = index_lt_count;
                    clr_index   = !index_lt_count;
                end
                StRepeat: begin
                    mode_leds   = 3'b100;
                    read_Memory = index_lt_count;
                    cnt_index   = index_lt_count && input_eq_pattern;
                    clr_index   = !(index_lt_count && input_eq_pattern);
                end
                StDone: begin
                    mode_leds   = 3'b111;
                    read_Memory = 1'b1;
                    cnt_index   = index_lt_count;
                    clr_index   = !index_lt_count;
                end
                default: mode_leds = 3'b001;
            endcase
        end
    end

endmodule

// File: doc/simon_control.md
Name: simon_control

Overview:
- Sequencing FSM for SimonDatapath; drives all datapath control strobes and the 3-bit mode LEDs.
- Walks the datapath through four phases: pattern entry (INPUT), sequence playback (PLAYBACK), player repeat (REPEAT) and game-over replay (DONE).
- Advances one step per rising edge of the user clock button; the datapath owns memory, count, index and level storage.

Parameters:
- MAX_ROUNDS, 64, number of pattern-memory entries; used only with SIMON_ROUND_CAP_EN.

Ports:
- clk  input  1  user clock (button); all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- is_legal  input  1  datapath: current switch pattern is legal for the latched level
- input_eq_pattern  input  1  datapath: switches equal mem[index]
- index_lt_count  input  1  datapath: index < count
- w_en  output  1  write switch pattern to mem[count]
- set_level  output  1  latch level switch into datapath
- read_Memory  output  1  pattern_leds source = mem[index] (else switches)
- cnt_count  output  1  count <= count+1
- clr_count  output  1  count <= 0
- cnt_index  output  1  index <= index+1
- clr_index  output  1  index <= 0
- mode_leds  output  3  INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111

Behaviour:
- State register, 2 bits; encodings INPUT, PLAYBACK, REPEAT, DONE.
- All outputs are combinational from state, inputs and reset. Datapath acts on them at the same clk edge as the state update.
- Strobes not listed for a state are 0.
- reset=1 (overrides everything):
  - set_level=1, clr_count=1, clr_index=1; all other strobes 0; mode_leds=001.
  - next state INPUT.
  - Mid-game reset behaves identically; no other state survives.
- INPUT (mode 001, read_Memory=0):
  - is_legal=1: w_en=1, cnt_count=1, clr_index=1; next PLAYBACK.
  - is_legal=0: no strobes; stay in INPUT.
- PLAYBACK (mode 010, read_Memory=1):
  - index_lt_count=1: cnt_index=1; stay.
  - index_lt_count=0: clr_index=1; next REPEAT.
  - Result: count+1 presses per playback. The last press ends playback while the LEDs show mem[count], a don't-care entry.
- REPEAT (mode 100):
  - read_Memory = index_lt_count.
  - index_lt_count=0 (all entries matched): clr_index=1; next INPUT.
  - index_lt_count=1, input_eq_pattern=1: cnt_index=1; stay.
  - index_lt_count=1, input_eq_pattern=0: clr_index=1; next DONE.
- DONE (mode 111, read_Memory=1):
  - index_lt_count=1: cnt_index=1.
  - index_lt_count=0: clr_index=1.
  - Loops through the stored sequence forever; exit only via reset.
- Never asserts cnt_index and clr_index in the same cycle, nor cnt_count and clr_count.
- w_en is asserted only together with cnt_count.

Optional Feature:
- Macro SIMON_ROUND_CAP_EN, defined:
  - Adds an internal 7-bit round counter, mirroring the datapath count.
  - Cleared on reset; incremented with cnt_count.
  - In REPEAT with index_lt_count=0, if rounds == MAX_ROUNDS: next state is DONE instead of INPUT (player wins; memory full), with clr_index=1.
- Macro undefined:
  - No counter; play continues indefinitely.
  - The datapath count wraps per its own width.

Test Plan:
- Reset: reset=1, one clk → mode_leds=001; set_level=clr_count=clr_index=1; w_en=0.
- Entry: is_legal=0, clk → stays INPUT, no strobes. Then is_legal=1 → w_en=cnt_count=clr_index=1 that cycle; after clk, mode_leds=010.
- Playback with count=2:
  - index_lt_count=1 for 2 clks → cnt_index each.
  - Then index_lt_count=0 → clr_index=1; after clk, mode_leds=100.
- Repeat, 2 entries:
  - input_eq_pattern=1 twice → cnt_index each.
  - Then index_lt_count=0 → clr_index=1, read_Memory=0; after clk, mode_leds=001.
- Mistake: in REPEAT, index_lt_count=1, input_eq_pattern=0 → clr_index=1; after clk, mode_leds=111. DONE then cycles cnt_index/clr_index across 5 clks. Assert reset → back to 001.
- SIMON_ROUND_CAP_EN, MAX_ROUNDS=2: complete 2 successful rounds → after the second REPEAT completion, mode_leds=111, not 001.
